// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the instruction-fetch slice.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package fetch_unit_pkg;

  typedef logic [15:0] lc3b_word;

  // FETCH: request outstanding at pc. HOLD: word parked, decode busy.
  // SQUASH: waiting out a response whose word must be thrown away.
  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    HOLD   = 2'd1,
    SQUASH = 2'd2
  } fetch_state_t;

  localparam lc3b_word RESET_PC_DEFAULT  = 16'h0000;
  localparam lc3b_word NOP_INSTR_DEFAULT = 16'h0000;  // BR with nzp=000

  // Instruction addresses are halfword aligned; bit0 is always dropped.
  function automatic lc3b_word align_pc(input lc3b_word addr);
    return addr & 16'hFFFE;
  endfunction

endpackage

// File: rtl/fetch_unit_if_id_reg.sv
// Fetch-to-decode pipeline register holding {instruction, pc, pc+2, valid}.
// Latency: one cycle from load to visible output.
// Backpressure: contents held until consumed (consume) or flushed; a load wins over consume.
//
// Ports: clk/rst, load + instr_in/pc_in/pc_plus2_in write a new word,
// flush drops the current word, consume clears valid when decode takes it,
// if_* are the registered outputs seen by decode.
module fetch_unit_if_id_reg
  import fetch_unit_pkg::*;
#(
  parameter lc3b_word NOP_INSTR = NOP_INSTR_DEFAULT
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     load,
  input  logic     flush,
  input  logic     consume,
  input  lc3b_word instr_in,
  input  lc3b_word pc_in,
  input  lc3b_word pc_plus2_in,
  output lc3b_word if_instruction,
  output lc3b_word if_pc,
  output lc3b_word if_pc_plus2,
  output logic     if_valid
);

  lc3b_word instr_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      instr_q     <= NOP_INSTR;
      if_pc       <= '0;
      if_pc_plus2 <= '0;
      if_valid    <= 1'b0;
    end else if (flush) begin
      if_valid <= 1'b0;
    end else if (load) begin
      instr_q     <= instr_in;
      if_pc       <= pc_in;
      if_pc_plus2 <= pc_plus2_in;
      if_valid    <= 1'b1;
    end else if (consume) begin
      if_valid <= 1'b0;
    end
  end

  // Decode must never see a stale word, so idle slots present the NOP.
  assign if_instruction = if_valid ? instr_q : NOP_INSTR;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, runs the imem read handshake, feeds decode.
// Latency: fetched word visible on if_* one cycle after imem_resp; 1 instr/cycle with zero-wait memory.
// Backpressure: a word returned while decode is stalled parks in a hold register and fetching pauses.
//
// Ports: clk/rst; imem_address/imem_read out and imem_rdata/imem_resp in
// form the memory handshake; id_ready is decode's accept; redirect/redirect_pc
// flush and retarget the PC; if_instruction/if_pc/if_pc_plus2/if_valid go to decode.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter lc3b_word RESET_PC  = RESET_PC_DEFAULT,
  parameter lc3b_word NOP_INSTR = NOP_INSTR_DEFAULT
) (
  input  logic     clk,
  input  logic     rst,
  output lc3b_word imem_address,
  output logic     imem_read,
  input  lc3b_word imem_rdata,
  input  logic     imem_resp,
  input  logic     id_ready,
  input  logic     redirect,
  input  lc3b_word redirect_pc,
  output lc3b_word if_instruction,
  output lc3b_word if_pc,
  output lc3b_word if_pc_plus2,
  output logic     if_valid
);

  fetch_state_t state, state_n;
  lc3b_word     pc, pc_n;
  lc3b_word     hold, hold_n;
  lc3b_word     redirect_latch, latch_n;
  lc3b_word     pc_plus2, redirect_target, id_instr;
  logic         slot_free, id_load, id_flush;

  assign pc_plus2        = pc + 16'd2;  // wraps FFFE -> 0000
  assign redirect_target = align_pc(redirect_pc);
  assign slot_free       = !if_valid || id_ready;
  assign imem_address    = pc;

  always_comb begin
    state_n   = state;
    pc_n      = pc;
    hold_n    = hold;
    latch_n   = redirect_latch;
    id_load   = 1'b0;
    id_flush  = 1'b0;
    id_instr  = imem_rdata;
    imem_read = 1'b0;
    case (state)
      FETCH: begin
        imem_read = 1'b1;
        if (redirect) begin
          id_flush = 1'b1;
          // The address must stay put while the old request is in flight,
          // so an unanswered redirect is parked until the response drains.
          if (imem_resp) begin
            pc_n = redirect_target;
          end else begin
            latch_n = redirect_target;
            state_n = SQUASH;
          end
        end else if (imem_resp) begin
          if (slot_free) begin
            id_load = 1'b1;
            pc_n    = pc_plus2;
          end else begin
            hold_n  = imem_rdata;
            state_n = HOLD;
          end
        end
      end
      HOLD: begin
        if (redirect) begin
          id_flush = 1'b1;
          pc_n     = redirect_target;
          state_n  = FETCH;
        end else if (slot_free) begin
          id_load  = 1'b1;
          id_instr = hold;
          pc_n     = pc_plus2;
          state_n  = FETCH;
        end
      end
      SQUASH: begin
        imem_read = 1'b1;
        if (redirect) begin
          id_flush = 1'b1;
          latch_n  = redirect_target;
        end
        if (imem_resp) begin
          pc_n    = redirect ? redirect_target : redirect_latch;
          state_n = FETCH;
        end
      end
      default: state_n = FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      // A request still in flight at reset will answer later with a word for
      // the old address; SQUASH swallows it, then refetches from RESET_PC
      // (the latch holds RESET_PC so the squash exit lands there).
      state          <= (imem_read && !imem_resp) ? SQUASH : FETCH;
      pc             <= align_pc(RESET_PC);
      hold           <= '0;
      redirect_latch <= align_pc(RESET_PC);
    end else begin
      state          <= state_n;
      pc             <= pc_n;
      hold           <= hold_n;
      redirect_latch <= latch_n;
    end
  end

  fetch_unit_if_id_reg #(
    .NOP_INSTR(NOP_INSTR)
  ) u_if_id_reg (
    .clk            (clk),
    .rst            (rst),
    .load           (id_load),
    .flush          (id_flush),
    .consume        (id_ready),
    .instr_in       (id_instr),
    .pc_in          (pc),
    .pc_plus2_in    (pc_plus2),
    .if_instruction (if_instruction),
    .if_pc          (if_pc),
    .if_pc_plus2    (if_pc_plus2),
    .if_valid       (if_valid)
  );

endmodule
